main_pipe_req_sched: RTL and testbench
======================================

MAIN_PIPE_REQ_SCHED -- requirements
Module: main_pipe_req_sched

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 15, meaning wait cycles before a low-priority requester overrides requester 0 (range 1..15).
REQ-002 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports io_in_<n>_valid  input  1  request valid, n=0 (miss refill), 1 (store), 2 (atomic).
REQ-005 SHALL have ports io_in_<n>_ready  output  1  request accepted this cycle, n=0..2.
REQ-006 SHALL have ports io_in_<n>_bits_addr  input  36  physical address, n=0..2.
REQ-007 SHALL have ports io_in_<n>_bits_cmd  input  5  memory command, n=0..2.
REQ-008 SHALL have ports io_in_<n>_bits_source  input  4  source tag, n=0..2.
REQ-009 SHALL have port io_out_valid  output  1  registered request to main pipe valid.
REQ-010 SHALL have port io_out_ready  input  1  main pipe accepts request.
REQ-011 SHALL have ports io_out_bits_addr/cmd/source  output  36/5/4  registered copy of granted request.
REQ-012 SHALL have port io_out_bits_grant_id  output  2  index of requester that supplied current output.
REQ-013 SHALL have port io_starve_hit  output  1  pulse: current cycle's grant was a starvation override.

Function
REQ-014 Output stage SHALL be a one-entry register; load_en = !io_out_valid | io_out_ready.
REQ-015 io_in_<n>_ready SHALL equal load_en & grant_n; grant SHALL be combinational from current valids and state, at most one grant per cycle.
REQ-016 Default priority SHALL be: requester 0 strictly over 1 and 2; between 1 and 2, round-robin pointer rr (0 selects 1 first, 1 selects 2 first).
REQ-017 Per requester m in {1,2}, 4-bit counter cnt_m SHALL increment each cycle io_in_m_valid & !fire_m, saturate at STARVE_LIMIT, and clear on fire_m or when !io_in_m_valid.
REQ-018 starved_m = (cnt_m == STARVE_LIMIT); any starved requester SHALL win over requester 0; if both starved, rr decides.
REQ-019 rr SHALL toggle to point away from the winner on every fire of requester 1 or 2; unchanged on requester-0 fire.
REQ-020 On fire (valid & ready of any input), output register SHALL load bits and grant_id; io_out_valid SHALL assert next cycle (latency 1).
REQ-021 If load_en and no input valid, io_out_valid SHALL clear next cycle.
REQ-022 While io_out_valid & !io_out_ready, output bits SHALL hold stable and all io_in_<n>_ready SHALL be 0.
REQ-023 Simultaneous output drain and new fire SHALL replace the register with no bubble (back-to-back throughput 1/cycle).
REQ-024 io_starve_hit SHALL be 1 exactly in cycles where a fire occurs to a starved requester while io_in_0_valid is 1.

Reset
REQ-025 On reset assertion, asynchronously: io_out_valid=0, io_out_bits_*=0, grant_id=0, cnt_1=cnt_2=0, rr=0, io_starve_hit=0.
REQ-026 Reset mid-transfer SHALL drop the held request; no input accepted while reset is high (all readies 0).

Verification
REQ-027 Single request: in1 valid, addr=0x1_0000_0040, cmd=0x01, out_ready=1 -> in1_ready=1 same cycle; next cycle out_valid=1, addr=0x1_0000_0040, grant_id=1.
REQ-028 Priority: in0 and in1 valid together, out_ready=1 -> in0 granted; in1 granted the cycle after in0 drops.
REQ-029 Round-robin: in1 and in2 continuously valid, in0 idle -> grant_id sequence 1,2,1,2.
REQ-030 Starvation: in0 and in2 continuously valid, STARVE_LIMIT=15 -> in2 granted on its 16th waiting cycle, io_starve_hit=1 that cycle, cnt_2 back to 0.
REQ-031 Back-pressure: out_valid=1, out_ready=0 for 5 cycles -> out bits unchanged, all in readies 0; on out_ready=1 pending in0 loads with no bubble.
REQ-032 Reset mid-operation: assert reset while out_valid=1 and cnt_1=7 -> out_valid=0, cnt_1=0 immediately, before next clock edge.

Source files
------------

// File: rtl/main_pipe_req_sched.sv
// Three-way request scheduler: fixed priority for refill (0), round-robin store/atomic (1/2) with starvation override.
// One-entry output register, latency 1; inputs are only accepted when the register is empty or draining.
module main_pipe_req_sched #(
  parameter int STARVE_LIMIT = 15
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        io_in_0_valid,
  output logic        io_in_0_ready,
  input  logic [35:0] io_in_0_bits_addr,
  input  logic [4:0]  io_in_0_bits_cmd,
  input  logic [3:0]  io_in_0_bits_source,

  input  logic        io_in_1_valid,
  output logic        io_in_1_ready,
  input  logic [35:0] io_in_1_bits_addr,
  input  logic [4:0]  io_in_1_bits_cmd,
  input  logic [3:0]  io_in_1_bits_source,

  input  logic        io_in_2_valid,
  output logic        io_in_2_ready,
  input  logic [35:0] io_in_2_bits_addr,
  input  logic [4:0]  io_in_2_bits_cmd,
  input  logic [3:0]  io_in_2_bits_source,

  output logic        io_out_valid,
  input  logic        io_out_ready,
  output logic [35:0] io_out_bits_addr,
  output logic [4:0]  io_out_bits_cmd,
  output logic [3:0]  io_out_bits_source,
  output logic [1:0]  io_out_bits_grant_id,

  output logic        io_starve_hit
);

  typedef struct packed {
    logic [35:0] addr;
    logic [4:0]  cmd;
    logic [3:0]  source;
  } req_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [2:0] in_vld;
  req_t       in_dat [3];

  assign in_vld    = {io_in_2_valid, io_in_1_valid, io_in_0_valid};
  assign in_dat[0] = '{addr: io_in_0_bits_addr, cmd: io_in_0_bits_cmd, source: io_in_0_bits_source};
  assign in_dat[1] = '{addr: io_in_1_bits_addr, cmd: io_in_1_bits_cmd, source: io_in_1_bits_source};
  assign in_dat[2] = '{addr: io_in_2_bits_addr, cmd: io_in_2_bits_cmd, source: io_in_2_bits_source};

  logic       out_vld_q, out_vld_d;
  req_t       out_dat_q, out_dat_d;
  logic [1:0] gid_q, gid_d;
  logic [3:0] cnt_1_q, cnt_1_d;
  logic [3:0] cnt_2_q, cnt_2_d;
  logic       rr_q, rr_d;

  logic       load_en;
  logic       starved_1, starved_2;
  logic [2:0] gnt;
  logic [2:0] fire;
  req_t       sel_dat;
  logic [1:0] sel_id;

  assign load_en   = !out_vld_q || io_out_ready;
  assign starved_1 = in_vld[1] && (cnt_1_q == LIMIT);
  assign starved_2 = in_vld[2] && (cnt_2_q == LIMIT);

  // Starved store/atomic beats refill; otherwise refill strictly first, then rr between 1 and 2.
  always_comb begin
    gnt = 3'b000;
    if (starved_1 && starved_2) begin
      gnt = rr_q ? 3'b100 : 3'b010;
    end else if (starved_1) begin
      gnt = 3'b010;
    end else if (starved_2) begin
      gnt = 3'b100;
    end else if (in_vld[0]) begin
      gnt = 3'b001;
    end else if (in_vld[1] && in_vld[2]) begin
      gnt = rr_q ? 3'b100 : 3'b010;
    end else if (in_vld[1]) begin
      gnt = 3'b010;
    end else if (in_vld[2]) begin
      gnt = 3'b100;
    end
  end

  // Readies are forced low while reset is held so nothing is consumed mid-reset.
  assign fire = gnt & {3{load_en && !reset}};

  assign io_in_0_ready = fire[0];
  assign io_in_1_ready = fire[1];
  assign io_in_2_ready = fire[2];

  assign io_starve_hit = in_vld[0] && ((fire[1] && starved_1) || (fire[2] && starved_2));

  always_comb begin
    sel_dat = in_dat[0];
    sel_id  = 2'd0;
    if (gnt[1]) begin
      sel_dat = in_dat[1];
      sel_id  = 2'd1;
    end else if (gnt[2]) begin
      sel_dat = in_dat[2];
      sel_id  = 2'd2;
    end
  end

  always_comb begin
    out_vld_d = out_vld_q;
    out_dat_d = out_dat_q;
    gid_d     = gid_q;
    if (load_en) begin
      out_vld_d = |fire;
      if (|fire) begin
        out_dat_d = sel_dat;
        gid_d     = sel_id;
      end
    end
  end

  always_comb begin
    cnt_1_d = cnt_1_q;
    if (!in_vld[1] || fire[1]) begin
      cnt_1_d = 4'd0;
    end else if (cnt_1_q != LIMIT) begin
      cnt_1_d = cnt_1_q + 4'd1;
    end
  end

  always_comb begin
    cnt_2_d = cnt_2_q;
    if (!in_vld[2] || fire[2]) begin
      cnt_2_d = 4'd0;
    end else if (cnt_2_q != LIMIT) begin
      cnt_2_d = cnt_2_q + 4'd1;
    end
  end

  // Pointer moves away from whichever of 1/2 just won; refill grants leave it alone.
  always_comb begin
    rr_d = rr_q;
    if (fire[1]) begin
      rr_d = 1'b1;
    end else if (fire[2]) begin
      rr_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      gid_q     <= 2'd0;
      cnt_1_q   <= 4'd0;
      cnt_2_q   <= 4'd0;
      rr_q      <= 1'b0;
    end else begin
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
      gid_q     <= gid_d;
      cnt_1_q   <= cnt_1_d;
      cnt_2_q   <= cnt_2_d;
      rr_q      <= rr_d;
    end
  end

  assign io_out_valid         = out_vld_q;
  assign io_out_bits_addr     = out_dat_q.addr;
  assign io_out_bits_cmd      = out_dat_q.cmd;
  assign io_out_bits_source   = out_dat_q.source;
  assign io_out_bits_grant_id = gid_q;

endmodule

// File: tb/tb_main_pipe_req_sched.sv
// Directed bench for main_pipe_req_sched: reset, round-robin, single request, priority,
// starvation override, back-pressure with no-bubble reload, and reset mid-operation.
module tb_main_pipe_req_sched;

  logic        clock = 1'b0;
  logic        reset;
  logic        in0_v, in1_v, in2_v;
  logic        in0_r, in1_r, in2_r;
  logic [35:0] in0_a, in1_a, in2_a;
  logic [4:0]  in0_c, in1_c, in2_c;
  logic [3:0]  in0_s, in1_s, in2_s;
  logic        out_v, out_r;
  logic [35:0] out_a;
  logic [4:0]  out_c;
  logic [3:0]  out_s;
  logic [1:0]  out_g;
  logic        starve_hit;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  main_pipe_req_sched #(.STARVE_LIMIT(15)) dut (
    .clock(clock), .reset(reset),
    .io_in_0_valid(in0_v), .io_in_0_ready(in0_r), .io_in_0_bits_addr(in0_a),
    .io_in_0_bits_cmd(in0_c), .io_in_0_bits_source(in0_s),
    .io_in_1_valid(in1_v), .io_in_1_ready(in1_r), .io_in_1_bits_addr(in1_a),
    .io_in_1_bits_cmd(in1_c), .io_in_1_bits_source(in1_s),
    .io_in_2_valid(in2_v), .io_in_2_ready(in2_r), .io_in_2_bits_addr(in2_a),
    .io_in_2_bits_cmd(in2_c), .io_in_2_bits_source(in2_s),
    .io_out_valid(out_v), .io_out_ready(out_r), .io_out_bits_addr(out_a),
    .io_out_bits_cmd(out_c), .io_out_bits_source(out_s), .io_out_bits_grant_id(out_g),
    .io_starve_hit(starve_hit)
  );

  task automatic clear_inputs();
    in0_v = 0; in1_v = 0; in2_v = 0;
    in0_a = '0; in1_a = '0; in2_a = '0;
    in0_c = '0; in1_c = '0; in2_c = '0;
    in0_s = '0; in1_s = '0; in2_s = '0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; out_r = 1; clear_inputs();
    in0_v = 1; in0_a = 36'h0_0000_1000;
    #2;
    if (out_v !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_v); end checks++;
    if (out_a !== 36'h0) begin errors++; $display("FAIL reset_out_addr got %h exp 0", out_a); end checks++;
    if (out_g !== 2'd0) begin errors++; $display("FAIL reset_grant_id got %0d exp 0", out_g); end checks++;
    if (starve_hit !== 1'b0) begin errors++; $display("FAIL reset_starve_hit got %0b exp 0", starve_hit); end checks++;
    if (in0_r !== 1'b0) begin errors++; $display("FAIL reset_in0_ready got %0b exp 0", in0_r); end checks++;
    step();
    if (out_v !== 1'b0) begin errors++; $display("FAIL reset_hold_valid got %0b exp 0", out_v); end checks++;
    reset = 0; clear_inputs();
    step();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g [4];
    exp_g[0] = 2'd1; exp_g[1] = 2'd2; exp_g[2] = 2'd1; exp_g[3] = 2'd2;
    in1_v = 1; in1_a = 36'h0_0000_0100; in1_c = 5'h01;
    in2_v = 1; in2_a = 36'h0_0000_0200; in2_c = 5'h04;
    for (int i = 0; i < 4; i++) begin
      step();
      if (out_g !== exp_g[i]) begin errors++; $display("FAIL rr_grant_%0d got %0d exp %0d", i, out_g, exp_g[i]); end checks++;
      if (out_a !== (exp_g[i] == 2'd1 ? 36'h0_0000_0100 : 36'h0_0000_0200)) begin
        errors++; $display("FAIL rr_addr_%0d got %h", i, out_a);
      end checks++;
    end
    clear_inputs();
    step();
  endtask

  task automatic test_single();
    out_r = 1;
    in1_v = 1; in1_a = 36'h1_0000_0040; in1_c = 5'h01; in1_s = 4'h3;
    #1;
    if (in1_r !== 1'b1) begin errors++; $display("FAIL single_in1_ready got %0b exp 1", in1_r); end checks++;
    if ({in0_r, in2_r} !== 2'b00) begin errors++; $display("FAIL single_other_ready got %b exp 00", {in0_r, in2_r}); end checks++;
    step();
    clear_inputs();
    if (out_v !== 1'b1) begin errors++; $display("FAIL single_out_valid got %0b exp 1", out_v); end checks++;
    if (out_a !== 36'h1_0000_0040) begin errors++; $display("FAIL single_addr got %h exp 100000040", out_a); end checks++;
    if (out_c !== 5'h01) begin errors++; $display("FAIL single_cmd got %h exp 01", out_c); end checks++;
    if (out_s !== 4'h3) begin errors++; $display("FAIL single_source got %h exp 3", out_s); end checks++;
    if (out_g !== 2'd1) begin errors++; $display("FAIL single_grant_id got %0d exp 1", out_g); end checks++;
    step();
    if (out_v !== 1'b0) begin errors++; $display("FAIL idle_clears_valid got %0b exp 0", out_v); end checks++;
  endtask

  task automatic test_priority();
    in0_v = 1; in0_a = 36'h0_0000_0A00; in0_c = 5'h02;
    in1_v = 1; in1_a = 36'h0_0000_0B00; in1_c = 5'h01;
    #1;
    if ({in1_r, in0_r} !== 2'b01) begin errors++; $display("FAIL prio_ready got %b exp 01", {in1_r, in0_r}); end checks++;
    step();
    if (out_g !== 2'd0 || out_a !== 36'h0_0000_0A00) begin
      errors++; $display("FAIL prio_first got id %0d addr %h exp id 0 addr a00", out_g, out_a);
    end checks++;
    in0_v = 0;
    #1;
    if (in1_r !== 1'b1) begin errors++; $display("FAIL prio_in1_ready got %0b exp 1", in1_r); end checks++;
    step();
    if (out_g !== 2'd1 || out_a !== 36'h0_0000_0B00) begin
      errors++; $display("FAIL prio_second got id %0d addr %h exp id 1 addr b00", out_g, out_a);
    end checks++;
    clear_inputs();
    step();
  endtask

  task automatic test_starvation();
    in0_v = 1; in0_a = 36'h0_0000_0C00;
    in2_v = 1; in2_a = 36'h0_0000_0D00; in2_c = 5'h08;
    for (int k = 1; k <= 16; k++) begin
      #1;
      if (in2_r !== (k == 16)) begin errors++; $display("FAIL starve_in2_ready_wait%0d got %0b", k, in2_r); end checks++;
      if (starve_hit !== (k == 16)) begin errors++; $display("FAIL starve_hit_wait%0d got %0b", k, starve_hit); end checks++;
      step();
    end
    if (out_g !== 2'd2 || out_a !== 36'h0_0000_0D00) begin
      errors++; $display("FAIL starve_grant got id %0d addr %h exp id 2 addr d00", out_g, out_a);
    end checks++;
    if (dut.cnt_2_q !== 4'd0) begin errors++; $display("FAIL starve_cnt2_clear got %0d exp 0", dut.cnt_2_q); end checks++;
    #1;
    if (in0_r !== 1'b1 || starve_hit !== 1'b0) begin
      errors++; $display("FAIL starve_after got in0_ready %0b hit %0b exp 1 0", in0_r, starve_hit);
    end checks++;
    clear_inputs();
    step();
  endtask

  task automatic test_back_to_back();
    out_r = 1;
    in1_v = 1; in1_a = 36'h0_0000_1111; in1_c = 5'h01;
    step();
    clear_inputs();
    out_r = 0;
    in0_v = 1; in0_a = 36'h0_0000_2222; in0_c = 5'h02;
    for (int i = 0; i < 5; i++) begin
      #1;
      if ({in2_r, in1_r, in0_r} !== 3'b000) begin errors++; $display("FAIL bp_ready_%0d got %b exp 000", i, {in2_r, in1_r, in0_r}); end checks++;
      step();
      if (out_v !== 1'b1 || out_a !== 36'h0_0000_1111 || out_g !== 2'd1) begin
        errors++; $display("FAIL bp_hold_%0d got v %0b addr %h id %0d exp 1 1111 1", i, out_v, out_a, out_g);
      end checks++;
    end
    out_r = 1;
    #1;
    if (in0_r !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %0b exp 1", in0_r); end checks++;
    step();
    if (out_v !== 1'b1 || out_a !== 36'h0_0000_2222 || out_g !== 2'd0) begin
      errors++; $display("FAIL bp_reload got v %0b addr %h id %0d exp 1 2222 0", out_v, out_a, out_g);
    end checks++;
    in0_a = 36'h0_0000_3333;
    step();
    if (out_v !== 1'b1 || out_a !== 36'h0_0000_3333) begin
      errors++; $display("FAIL b2b_next got v %0b addr %h exp 1 3333", out_v, out_a);
    end checks++;
    clear_inputs();
    step();
    if (out_v !== 1'b0) begin errors++; $display("FAIL b2b_drain got %0b exp 0", out_v); end checks++;
  endtask

  task automatic test_reset_mid();
    in0_v = 1; in0_a = 36'h0_0000_4444;
    in1_v = 1; in1_a = 36'h0_0000_5555;
    for (int i = 0; i < 7; i++) step();
    if (dut.cnt_1_q !== 4'd7 || out_v !== 1'b1) begin
      errors++; $display("FAIL mid_precond got cnt1 %0d v %0b exp 7 1", dut.cnt_1_q, out_v);
    end checks++;
    reset = 1;
    #1;
    if (out_v !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %0b exp 0", out_v); end checks++;
    if (dut.cnt_1_q !== 4'd0) begin errors++; $display("FAIL mid_cnt1 got %0d exp 0", dut.cnt_1_q); end checks++;
    if (out_a !== 36'h0 || out_g !== 2'd0) begin errors++; $display("FAIL mid_bits got addr %h id %0d exp 0 0", out_a, out_g); end checks++;
    if ({in1_r, in0_r} !== 2'b00) begin errors++; $display("FAIL mid_ready got %b exp 00", {in1_r, in0_r}); end checks++;
    #3;
    reset = 0;
    clear_inputs();
    step();
    if (out_v !== 1'b0) begin errors++; $display("FAIL mid_after got %0b exp 0", out_v); end checks++;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_priority();
    test_starvation();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
